// File: rtl/xs3_to_bcd_serial_pkg.sv
// Shared constants and FSM state encoding for the bit-serial excess-3 to BCD decoder.
package xs3_to_bcd_serial_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam logic [3:0]  XS3_BIAS = 4'b0011;
  localparam logic [3:0]  BCD_MAX  = 4'd9;

  // Encoding is {bit position[1:0], borrow}; S0 carries no borrow.
  typedef enum logic [2:0] {
    S0   = 3'b000,
    S1B0 = 3'b010,
    S1B1 = 3'b011,
    S2B0 = 3'b100,
    S2B1 = 3'b101,
    S3B0 = 3'b110,
    S3B1 = 3'b111
  } xs3_state_e;

endpackage

// File: rtl/xs3_serial_sub.sv
// Borrow FSM and bit counter: subtracts 0011 from an LSB-first excess-3 stream.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   in_valid_i     accept x_i this cycle
//   x_i            excess-3 data bit
//   in_first_i     treat this bit as bit 0 of a digit, whatever the state
//   z_o            difference bit for the current bit (combinational, Mealy)
//   pos_o          bit position of the current bit within its digit
//   borrow_o       borrow out of the current bit
//   last_o         current bit is bit 3 of its digit
module xs3_serial_sub
  import xs3_to_bcd_serial_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic       x_i,
  input  logic       in_first_i,
  output logic       z_o,
  output logic [1:0] pos_o,
  output logic       borrow_o,
  output logic       last_o
);

  xs3_state_e state_q, state_d, cur_state;
  logic [2:0] cur_bits;
  logic       s_bit, b_in, b_next;

  always_comb begin
    cur_state = in_first_i ? S0 : state_q;
    cur_bits  = cur_state;
    pos_o     = cur_bits[2:1];
    b_in      = cur_bits[0];
    s_bit     = XS3_BIAS[pos_o];
    z_o       = x_i ^ s_bit ^ b_in;
    b_next    = (~x_i & (s_bit | b_in)) | (s_bit & b_in);
    borrow_o  = b_next;
    last_o    = (pos_o == 2'd3);

    state_d = state_q;
    if (in_valid_i) begin
      if (last_o) state_d = S0;
      else        state_d = xs3_state_e'({pos_o + 2'd1, b_next});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S0;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/xs3_to_bcd_serial.sv
// Bit-serial excess-3 to BCD decoder with digit assembly and word packing.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid      qualifies x_in; other cycles are bubbles
//   x_in          excess-3 bit, LSB first, 4 bits per digit
//   in_first      resync: bit 0 of digit 0 of a new word
//   z_out/z_valid decoded BCD bit, one cycle after acceptance
//   digit/digit_valid/digit_err    last completed digit and its error flag
//   bcd_word/word_valid/word_err   last completed word (digit k at [4k+3:4k])
module xs3_to_bcd_serial
  import xs3_to_bcd_serial_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    x_in,
  input  logic                    in_first,
  output logic                    z_out,
  output logic                    z_valid,
  output logic [DIGIT_W-1:0]      digit,
  output logic                    digit_valid,
  output logic                    digit_err,
  output logic [DIGIT_W*DIGITS-1:0] bcd_word,
  output logic                    word_valid,
  output logic                    word_err
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic       z, borrow, last;
  logic [1:0] pos;

  xs3_serial_sub u_sub (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .x_i        (x_in),
    .in_first_i (in_first),
    .z_o        (z),
    .pos_o      (pos),
    .borrow_o   (borrow),
    .last_o     (last)
  );

  logic                      z_out_q, z_valid_q;
  logic [DIGIT_W-1:0]        digit_q;
  logic                      digit_valid_q, digit_err_q;
  logic [DIGIT_W*DIGITS-1:0] bcd_word_q, word_part_q, word_d;
  logic                      word_valid_q, word_err_q;
  logic [2:0]                part_q;
  logic [CntW-1:0]           digit_cnt_q, cnt_eff;
  logic                      err_acc_q, err_acc_eff;
  logic [DIGIT_W-1:0]        digit_full;
  logic                      dig_err, word_last;

  always_comb begin
    // A resync restarts the word at digit 0 with a clean error accumulator.
    cnt_eff     = in_first ? '0 : digit_cnt_q;
    err_acc_eff = in_first ? 1'b0 : err_acc_q;
    digit_full  = {z, part_q};
    // Final borrow means code < 0011; result above 9 means code > 1100.
    dig_err     = borrow | (digit_full > BCD_MAX);
    word_last   = (cnt_eff == CntW'(DIGITS - 1));
    word_d      = word_part_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (cnt_eff == CntW'(k)) word_d[k*DIGIT_W +: DIGIT_W] = digit_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_out_q       <= 1'b0;
      z_valid_q     <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      bcd_word_q    <= '0;
      word_part_q   <= '0;
      word_valid_q  <= 1'b0;
      word_err_q    <= 1'b0;
      part_q        <= '0;
      digit_cnt_q   <= '0;
      err_acc_q     <= 1'b0;
    end else begin
      z_valid_q     <= 1'b0;
      digit_valid_q <= 1'b0;
      word_valid_q  <= 1'b0;
      if (in_valid) begin
        z_out_q   <= z;
        z_valid_q <= 1'b1;
        case (pos)
          2'd0:    part_q[0] <= z;
          2'd1:    part_q[1] <= z;
          2'd2:    part_q[2] <= z;
          default: ;
        endcase
        if (last) begin
          digit_q       <= digit_full;
          digit_err_q   <= dig_err;
          digit_valid_q <= 1'b1;
          word_part_q   <= word_d;
          if (word_last) begin
            bcd_word_q   <= word_d;
            word_err_q   <= err_acc_eff | dig_err;
            word_valid_q <= 1'b1;
            digit_cnt_q  <= '0;
            err_acc_q    <= 1'b0;
          end else begin
            digit_cnt_q <= cnt_eff + CntW'(1);
            err_acc_q   <= err_acc_eff | dig_err;
          end
        end else begin
          digit_cnt_q <= cnt_eff;
          err_acc_q   <= err_acc_eff;
        end
      end
    end
  end

  assign z_out       = z_out_q;
  assign z_valid     = z_valid_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign digit_err   = digit_err_q;
  assign bcd_word    = bcd_word_q;
  assign word_valid  = word_valid_q;
  assign word_err    = word_err_q;

endmodule

// File: doc/xs3_to_bcd_serial.md
Name: xs3_to_bcd_serial

Overview:
- Bit-serial excess-3 to BCD decoder. It is the receive-side counterpart of the team's BCD-to-excess-3 converter.
- Accepts an excess-3 bit stream, LSB first, 4 bits per digit. It subtracts 0011 bit-serially with a Mealy borrow FSM.
- Emits each BCD bit one cycle later, assembles digits, packs DIGITS digits into a word, and flags invalid codes.

Parameters:
- DIGITS, 2, BCD digits per output word (≥1); digit 0 is the least significant and arrives first.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies x_in this cycle; cycles without it are bubbles (no state change).
- x_in  in  1  excess-3 data bit, LSB first.
- in_first  in  1  marks x_in as bit 0 of digit 0 of a new word; only meaningful with in_valid.
- z_out  out  1  decoded BCD bit (registered).
- z_valid  out  1  z_out valid, 1-cycle pulse per accepted bit.
- digit  out  4  last completed BCD digit.
- digit_valid  out  1  1-cycle pulse when digit updates.
- digit_err  out  1  qualifies digit; set if the excess-3 code is outside 0011..1100.
- bcd_word  out  4*DIGITS  completed word; digit k sits at bits [4k+3:4k].
- word_valid  out  1  1-cycle pulse when bcd_word updates.
- word_err  out  1  OR of digit_err over the word's digits.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0.
  - bit_cnt=0, digit_cnt=0, borrow=0, partial shift regs=0.
  - rst overrides in_valid in the same cycle.
  - Reset mid-digit or mid-word discards partial data; no pulses are emitted.
- Subtrahend bit s = 1 for bit_cnt 0,1 and 0 for bit_cnt 2,3. Borrow-in at bit 0 is 0.
- Per accepted bit:
  - z = x ^ s ^ b
  - b_next = (~x & (s | b)) | (s & b)
- FSM has 7 states, as (bit position, borrow): S0; S1B0, S1B1; S2B0, S2B1; S3B0, S3B1.
  - S0 -> S1B{~x}.
  - SnBb -> S(n+1)B{b_next}.
  - S3x -> S0.
  - Only transitions when in_valid=1.
- in_first=1 with in_valid=1 forces the bit to be treated as bit 0 of digit 0, regardless of state. Any partial digit and word are discarded silently.
- Latency:
  - Bit accepted at edge t: z_out/z_valid valid in cycle t+1.
  - 4th bit at t: digit, digit_err, digit_valid in cycle t+1, simultaneous with that bit's z_valid.
- digit_err = final borrow (code < 0011) OR result > 1001 (code > 1100).
  - The erroneous raw difference is still shown on digit, truncated to 4 bits.
- Digit DIGITS-1 completing: word_valid, bcd_word and word_err in the same cycle as its digit_valid. digit_cnt wraps to 0.
- Streams continue without requiring in_first per word; in_first is only a resync.
- Outputs hold their last value between pulses. Pulses are exactly 1 cycle even when in_valid is continuously high.
- Back-to-back digits with no bubble are fully supported: throughput is 1 bit/clk.

Decomposition:
- Shared package/include:
  - XS3_BIAS = 4'b0011
  - BCD_MAX = 4'd9
  - state encodings for the 7 FSM states
  - DIGIT_W = 4
- One natural sub-module, xs3_serial_sub: the borrow FSM plus bit counter, producing z, bit position and end-of-digit.
- Top-level xs3_to_bcd_serial handles digit assembly, error check and word packing.

Test Plan:
- Reset then stream 1100 LSB-first (0,0,1,1), no bubbles: z_out sequence 1,0,0,1; digit=1001, digit_valid in the cycle after the 4th bit, digit_err=0.
- Codes 0011 then 0000: first digit=0000 err=0. Second digit_err=1 (borrow); word_valid with word_err=1, bcd_word[3:0]=0000.
- Code 1101: digit=1010, digit_err=1.
- DIGITS=2, with bubbles between bits, LSD 1000 then MSD 1011: bcd_word=0x85, word_valid exactly once, word_err=0.
- Two bits of 1100 sent, then in_first with full code 0100 then 0110: no digit_valid for the partial; digits 0001, 0011; word=0x31.
- rst asserted after bit 2 of digit 1: no pulses. A fresh word 0011,0011 afterwards yields word=0x00, word_err=0.
